// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider.
// Provides the FSM state encoding, the default operand width and the
// step-counter width helper used by the divider top.
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // The step counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_if.sv
// Handshake/result bundle for the divider.
// master: drives start, x (dividend), y (divisor); sees busy, done, q, r, div_zero_r.
// slave : the divider itself.
interface divider_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero_r;

    modport master (
        output start, x, y,
        input  busy, done, q, r, div_zero_r
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, div_zero_r
    );

endinterface

// File: rtl/divider_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem_in   - partial remainder before the step (always < divisor)
//   dvd_msb  - next dividend bit, shifted in at the LSB of the remainder
//   divisor  - divisor
//   rem_out  - partial remainder after the step
//   q_bit    - quotient bit produced by this step
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // rem_in can have its MSB set when the divisor is large, so the shifted
    // value needs one extra bit; after a subtract it fits back in WIDTH bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(diff) : WIDTH'(shifted);
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - divider_if slave: start/x/y in, busy/done/q/r/div_zero_r out
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; operands latched on accept
// RUN     | one restoring step per cycle, WIDTH cycles total
// DONE    | result ready; done/q/r/div_zero_r updated on the leaving edge
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;      // dividend, shifted out MSB-first; collects quotient at LSB
    logic [WIDTH-1:0] dvs;
    logic             dz;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem),
        .dvd_msb(dvd[WIDTH-1]),
        .divisor(dvs),
        .rem_out(rem_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.y == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (step_cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem            <= '0;
            dvd            <= '0;
            dvs            <= '0;
            step_cnt       <= '0;
            dz             <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.q          <= '0;
            bus.r          <= '0;
            bus.div_zero_r <= 1'b0;
        end else begin
            bus.busy <= (state_nxt != ST_IDLE);
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        dvd      <= bus.x;
                        dvs      <= bus.y;
                        rem      <= '0;
                        step_cnt <= '0;
                        dz       <= (bus.y == '0);
                    end
                end
                ST_RUN: begin
                    rem      <= rem_step;
                    dvd      <= {dvd[WIDTH-2:0], q_bit};
                    step_cnt <= step_cnt + 1'b1;
                end
                ST_DONE: begin
                    // On divide-by-zero dvd still holds the untouched dividend.
                    bus.done       <= 1'b1;
                    bus.q          <= dz ? '1 : dvd;
                    bus.r          <= dz ? dvd : rem;
                    bus.div_zero_r <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;
    localparam int TMO   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    divider_if #(.WIDTH(WIDTH)) bus ();

    divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] eq, output logic [WIDTH-1:0] er,
                                    output logic ez, output int elat);
        if (b == 0) begin
            eq   = {WIDTH{1'b1}};
            er   = a;
            ez   = 1'b1;
            elat = 1;
        end else begin
            eq   = a / b;
            er   = a % b;
            ez   = 1'b0;
            elat = LAT;
        end
    endfunction

    // Issues one start pulse and returns edges from accept to done-visible.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int edges);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        edges = 0;
        while (bus.done !== 1'b1 && edges < TMO) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.q !== 8'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", bus.q); end
        n_vec++; if (bus.r !== 8'd0) begin n_err++; $display("FAIL reset_r: got %0d want 0", bus.r); end
        n_vec++; if (bus.div_zero_r !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", bus.div_zero_r); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int edges;
        run_op(8'd100, 8'd7, edges);
        n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL basic_lat: got %0d want %0d", edges, LAT); end
        n_vec++; if (bus.q !== 8'd14) begin n_err++; $display("FAIL basic_q: got %0d want 14", bus.q); end
        n_vec++; if (bus.r !== 8'd2) begin n_err++; $display("FAIL basic_r: got %0d want 2", bus.r); end
        n_vec++; if (bus.div_zero_r !== 1'b0) begin n_err++; $display("FAIL basic_dz: got %b want 0", bus.div_zero_r); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_identity();
        int edges;
        run_op(8'd255, 8'd1, edges);
        n_vec++; if (bus.q !== 8'd255) begin n_err++; $display("FAIL div1_q: got %0d want 255", bus.q); end
        n_vec++; if (bus.r !== 8'd0) begin n_err++; $display("FAIL div1_r: got %0d want 0", bus.r); end
        run_op(8'd255, 8'd255, edges);
        n_vec++; if (bus.q !== 8'd1) begin n_err++; $display("FAIL divself_q: got %0d want 1", bus.q); end
        n_vec++; if (bus.r !== 8'd0) begin n_err++; $display("FAIL divself_r: got %0d want 0", bus.r); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", bus.done); end
        n_vec++; if (bus.q !== 8'd1) begin n_err++; $display("FAIL hold_q: got %0d want 1", bus.q); end
    endtask

    task automatic test_div_zero();
        int edges;
        run_op(8'd37, 8'd0, edges);
        n_vec++; if (edges !== 1) begin n_err++; $display("FAIL dz_lat: got %0d want 1", edges); end
        n_vec++; if (bus.q !== 8'd255) begin n_err++; $display("FAIL dz_q: got %0d want 255", bus.q); end
        n_vec++; if (bus.r !== 8'd37) begin n_err++; $display("FAIL dz_r: got %0d want 37", bus.r); end
        n_vec++; if (bus.div_zero_r !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", bus.div_zero_r); end
        run_op(8'd0, 8'd13, edges);
        n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL x0_lat: got %0d want %0d", edges, LAT); end
        n_vec++; if (bus.q !== 8'd0 || bus.r !== 8'd0) begin n_err++; $display("FAIL x0_qr: got q=%0d r=%0d want 0 0", bus.q, bus.r); end
        n_vec++; if (bus.div_zero_r !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b want 0", bus.div_zero_r); end
    endtask

    task automatic test_ignore_start();
        int edges;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 8'd200;
        bus.y     = 8'd9;
        @(posedge clk);
        @(negedge clk);
        edges = 0;
        while (bus.done !== 1'b1 && edges < TMO) begin
            n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_run: got %b want 1 at edge %0d", bus.busy, edges); end
            // start re-pulsed mid-run and again while in DONE; both must be ignored
            if (edges == 2 || edges == LAT - 1) begin
                bus.start = 1'b1;
                bus.x     = 8'd5;
                bus.y     = 8'd5;
            end else begin
                bus.start = 1'b0;
                bus.x     = WIDTH'($urandom);
                bus.y     = WIDTH'($urandom);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL ign_lat: got %0d want %0d", edges, LAT); end
        n_vec++; if (bus.q !== 8'd22) begin n_err++; $display("FAIL ign_q: got %0d want 22", bus.q); end
        n_vec++; if (bus.r !== 8'd2) begin n_err++; $display("FAIL ign_r: got %0d want 2", bus.r); end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL done_start_ignored: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        int done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 8'd100;
        bus.y     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL rst_run_ctl: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        n_vec++; if (bus.q !== 8'd0 || bus.r !== 8'd0 || bus.div_zero_r !== 1'b0) begin n_err++; $display("FAIL rst_run_res: got q=%0d r=%0d dz=%b want 0", bus.q, bus.r, bus.div_zero_r); end
        bus.start = 1'b1;
        bus.x     = 8'd9;
        bus.y     = 8'd2;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_prio: busy got %b want 0", bus.busy); end
        rst       = 1'b0;
        bus.start = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d pulses want 0", done_seen); end
        run_op(8'd50, 8'd6, edges);
        n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL post_rst_lat: got %0d want %0d", edges, LAT); end
        n_vec++; if (bus.q !== 8'd8 || bus.r !== 8'd2) begin n_err++; $display("FAIL post_rst_qr: got q=%0d r=%0d want 8 2", bus.q, bus.r); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b, eq, er;
        logic             ez;
        int               elat, edges;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom_range(1, 255));
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        for (int i = 0; i < 1000; i++) begin
            ref_div(a, b, eq, er, ez, elat);
            @(posedge clk);
            edges = 0;
            @(negedge clk);
            while (bus.done !== 1'b1 && edges < TMO) begin
                bus.x = WIDTH'($urandom);
                bus.y = WIDTH'($urandom);
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            n_vec++; if (edges !== elat) begin n_err++; $display("FAIL b2b_lat[%0d]: x=%0d y=%0d got %0d want %0d", i, a, b, edges, elat); end
            n_vec++; if (bus.q !== eq) begin n_err++; $display("FAIL b2b_q[%0d]: x=%0d y=%0d got %0d want %0d", i, a, b, bus.q, eq); end
            n_vec++; if (bus.r !== er) begin n_err++; $display("FAIL b2b_r[%0d]: x=%0d y=%0d got %0d want %0d", i, a, b, bus.r, er); end
            n_vec++; if (bus.div_zero_r !== ez) begin n_err++; $display("FAIL b2b_dz[%0d]: got %b want %b", i, bus.div_zero_r, ez); end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (i % 50 == 7) b = '0;
            if (i % 41 == 5) b = 8'd1;
            if (i % 43 == 9) b = 8'd255;
            if (i % 37 == 3) a = '0;
            bus.x = a;
            bus.y = b;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_identity();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
